// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage: bubble encoding, reset PC,
// fetch FSM state encodings and the skid-buffer entry layout.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DROP = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } skid_entry_t;

    // Instruction fetch is always word granular.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} holding register for a response decode could not take.
// Latency: loaded entry is visible (full=1) the cycle after load.
// Backpressure: none internally; the owner stops requesting while full is set.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  skid_entry_t load_entry,
    output logic        full,
    output skid_entry_t entry
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else begin
            if (clear || drain) begin
                full <= 1'b0;
            end
            if (load) begin
                full  <= 1'b1;
                entry <= load_entry;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage + IF/ID register; FETCH_PERF_EN adds bubble/stall counters.
// Latency: first valid_D 3 cycles after reset release (gnt same cycle, rvalid next); 1 instr/cycle sustained.
// Backpressure: stall holds IF/ID; a response landing under stall parks in a skid and requests pause until it drains.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d, pc_f_inc, redirect_al;
    logic         rsp_vld, rsp_accept, skid_load, skid_drain, skid_full;
    skid_entry_t  skid_in, skid_out;

    assign pc_f_inc    = pc_f_q + 32'd4;
    assign redirect_al = word_align(redirect_pc);
    assign rsp_vld     = (state_q == WAIT) && imem_rvalid;
    assign rsp_accept  = rsp_vld && !flush && !stall && !skid_full;
    assign skid_load   = rsp_vld && !flush && (stall || skid_full);
    assign skid_drain  = skid_full && !stall && !flush;
    assign skid_in     = {imem_rdata, pc_f_q};

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (flush),
        .load_entry (skid_in),
        .full       (skid_full),
        .entry      (skid_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_f_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
        end
    end

    // pc_f_q is the address of the outstanding request in WAIT, the next one otherwise.
    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        imem_req  = 1'b0;
        imem_addr = word_align(pc_f_q);
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush) pc_f_d = redirect_al;
            end
            REQ: begin
                imem_req = !skid_full;
                if (flush) begin
                    pc_f_d = redirect_al;
                    if (imem_req && imem_gnt) state_d = DROP;
                end else if (imem_req && imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        pc_f_d  = redirect_al;
                        state_d = REQ;
                    end else begin
                        pc_f_d  = pc_f_inc;
                        state_d = REQ;
                        if (rsp_accept) begin
                            imem_req  = 1'b1;
                            imem_addr = word_align(pc_f_inc);
                            if (imem_gnt) state_d = WAIT;
                        end
                    end
                end else if (flush) begin
                    pc_f_d  = redirect_al;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (flush) pc_f_d = redirect_al;
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= 32'd0;
            pc4_D   <= 32'd4;
            valid_D <= 1'b0;
        end else if (flush) begin
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
        end else if (stall) begin
            instr_D <= instr_D;
        end else if (skid_full) begin
            instr_D <= skid_out.instr;
            pc_D    <= skid_out.pc;
            pc4_D   <= skid_out.pc + 32'd4;
            valid_D <= 1'b1;
        end else if (rsp_accept) begin
            instr_D <= imem_rdata;
            pc_D    <= pc_f_q;
            pc4_D   <= pc_f_inc;
            valid_D <= 1'b1;
        end else begin
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble_load;
    assign bubble_load = !stall && (flush || (!skid_full && !rsp_accept));

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_bubble_cnt <= 32'd0;
            perf_stall_cnt  <= 32'd0;
        end else begin
            if (bubble_load && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a responder models instruction memory
// (gnt + configurable rvalid latency); each task drives one scenario and checks inline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_D, pc_D, pc4_D;
    logic        valid_D;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_stall_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          gnt_en = 1'b1;
    int          lat = 1;
    logic [31:0] salt = 32'd0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] salt;
        int          due;
    } pend_t;
    pend_t pq[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc4_D       (pc4_D),
        .valid_D     (valid_D)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    // Memory responder: present due response at negedge, then sample req/gnt 1ns later.
    initial begin
        forever begin
            @(negedge clk);
            if (pq.size() > 0 && pq[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pq[0].addr) ^ pq[0].salt;
                void'(pq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            #1;
            imem_gnt = gnt_en;
            if (imem_req && imem_gnt) pq.push_back('{addr: imem_addr, salt: salt, due: cyc + lat});
        end
    end

    task automatic do_reset(input int l);
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
        gnt_en = 1'b1; lat = l; salt = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (instr_D !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_D, NOP); end
        n_checks++; if (pc_D !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_D, 32'd0); end
        n_checks++; if (pc4_D !== 32'd4) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", pc4_D, 32'd4); end
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_D); end
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    endtask

    task automatic test_first_fetch;
        do_reset(1);
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL ff_valid_c1: got %b want 0", valid_D); end
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL ff_req0: req %b addr %h want 1 00000000", imem_req, imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL ff_valid_c2: got %b want 0", valid_D); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid_D !== 1'b1 || pc_D !== 32'(4 * i) || instr_D !== instr_of(32'(4 * i))) begin
                n_fail++; $display("FAIL ff_seq%0d: valid %b pc %h instr %h want 1 %h %h", i, valid_D, pc_D, instr_D, 32'(4 * i), instr_of(32'(4 * i)));
            end
            if (i == 0) begin
                n_checks++; if (pc4_D !== 32'd4) begin n_fail++; $display("FAIL ff_pc4: got %h want 00000004", pc4_D); end
            end
        end
    endtask

    task automatic test_stall;
        bit found;
        do_reset(1);
        repeat (6) @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h0C) begin n_fail++; $display("FAIL st_pre: valid %b pc %h want 1 0000000c", valid_D, pc_D); end
        stall = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_D !== 32'h0C || instr_D !== instr_of(32'h0C) || valid_D !== 1'b1) begin n_fail++; $display("FAIL st_hold1: pc %h instr %h want 0000000c %h", pc_D, instr_D, instr_of(32'h0C)); end
        @(negedge clk);
        n_checks++; if (pc_D !== 32'h0C || instr_D !== instr_of(32'h0C)) begin n_fail++; $display("FAIL st_hold2: pc %h instr %h want 0000000c", pc_D, instr_D); end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h10 || instr_D !== instr_of(32'h10)) begin n_fail++; $display("FAIL st_skid: valid %b pc %h instr %h want 1 00000010 %h", valid_D, pc_D, instr_D, instr_of(32'h10)); end
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (valid_D === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found || pc_D !== 32'h14 || instr_D !== instr_of(32'h14)) begin n_fail++; $display("FAIL st_next: found %b pc %h want 1 00000014", found, pc_D); end
    endtask

    task automatic test_flush_wait;
        do_reset(3);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0; lat = 1;
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fw_valid3: got %b want 0", valid_D); end
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fw_drop_req: got %b want 0", imem_req); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fw_valid4: got %b want 0", valid_D); end
        @(negedge clk);
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL fw_req: req %b addr %h want 1 00000080", imem_req, imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fw_valid6: got %b want 0", valid_D); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h80 || instr_D !== instr_of(32'h80)) begin n_fail++; $display("FAIL fw_target: valid %b pc %h instr %h want 1 00000080 %h", valid_D, pc_D, instr_D, instr_of(32'h80)); end
    endtask

    task automatic test_flush_stall;
        bit found;
        do_reset(1);
        repeat (4) @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h4) begin n_fail++; $display("FAIL fs_pre: valid %b pc %h want 1 00000004", valid_D, pc_D); end
        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        n_checks++; if (instr_D !== NOP || valid_D !== 1'b0) begin n_fail++; $display("FAIL fs_bubble: instr %h valid %b want %h 0", instr_D, valid_D, NOP); end
        flush = 1'b0; stall = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL fs_req: req %b addr %h want 1 00000040", imem_req, imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (valid_D === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found || pc_D !== 32'h40) begin n_fail++; $display("FAIL fs_target: found %b pc %h want 1 00000040", found, pc_D); end
    endtask

    task automatic test_align_wrap;
        do_reset(1);
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL aw_align: req %b addr %h want 1 00000100", imem_req, imem_addr); end
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL aw_top: req %b addr %h want 1 fffffffc", imem_req, imem_addr); end
        @(negedge clk);
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL aw_wrap_addr: req %b addr %h want 1 00000000", imem_req, imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'hFFFF_FFFC || pc4_D !== 32'h0) begin n_fail++; $display("FAIL aw_top_D: valid %b pc %h pc4 %h want 1 fffffffc 00000000", valid_D, pc_D, pc4_D); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h0 || instr_D !== instr_of(32'h0)) begin n_fail++; $display("FAIL aw_wrap_D: valid %b pc %h want 1 00000000", valid_D, pc_D); end
    endtask

    task automatic test_reset_mid;
        do_reset(3);
        @(negedge clk);
        salt = 32'h0F00_0000;
        @(negedge clk);
        salt = 32'd0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; lat = 1;
        n_checks++; if (instr_D !== NOP || valid_D !== 1'b0 || pc_D !== 32'd0 || pc4_D !== 32'd4) begin n_fail++; $display("FAIL rm_regs: instr %h valid %b pc %h pc4 %h", instr_D, valid_D, pc_D, pc4_D); end
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_idle: got %b want 0", imem_req); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL rm_valid4: got %b want 0", valid_D); end
        #2;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: req %b addr %h want 1 00000000", imem_req, imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL rm_valid5: got %b want 0", valid_D); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || pc_D !== 32'h0 || instr_D !== instr_of(32'h0)) begin n_fail++; $display("FAIL rm_fresh: valid %b pc %h instr %h want 1 00000000 %h", valid_D, pc_D, instr_D, instr_of(32'h0)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_flush_wait();
        test_flush_stall();
        test_align_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC, issues instruction-memory requests over a req/gnt/rvalid handshake, and presents instr_D/pc_D to decode.
- Consumes stall from the stall unit (holds IF/ID on load-use) and flush/redirect_pc from execute (taken branch/jump).
- One-entry skid buffer absorbs a fetch response that arrives while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- stall  in  1  hold IF/ID and suppress PC advance to decode
- flush  in  1  taken branch/jump resolved in E; kill IF/ID and redirect
- redirect_pc  in  32  target PC, valid when flush=1
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  fetched instruction
- instr_D  out  32  instruction to decode
- pc_D  out  32  PC of instr_D
- pc4_D  out  32  pc_D+4, for jal/jalr link
- valid_D  out  1  instr_D is a real instruction (0 = bubble)

Behaviour:
- Reset (reset==0 at clk edge): pc_F=RESET_PC, state=IDLE, skid empty, instr_D=NOP_INSTR, pc_D=0, pc4_D=4, valid_D=0, imem_req=0.
- States: IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE -> REQ unconditionally, one cycle after reset release.
- REQ: imem_req=!skid_full, imem_addr=pc_F. On gnt -> WAIT.
  - flush without gnt: pc_F<=redirect_pc; stay REQ.
  - flush with gnt: pc_F<=redirect_pc; -> DROP.
- WAIT, no rvalid: hold. flush -> pc_F<=redirect_pc; -> DROP.
- WAIT, rvalid, no flush: pc_F<=pc_F+4.
  - If !stall and skid empty: data loads IF/ID; imem_req=1 same cycle with addr pc_F+4 (back-to-back). gnt -> stay WAIT; else -> REQ.
  - Otherwise: data goes to skid (skid_pc=pc_F); -> REQ with imem_req held 0 until skid drains.
- WAIT, rvalid and flush same cycle: discard data; pc_F<=redirect_pc; -> REQ.
- DROP: imem_req=0. Discard the next rvalid, then -> REQ. A further flush in DROP updates pc_F only.
- IF/ID update priority:
  - flush: instr_D=NOP_INSTR, valid_D=0, skid cleared.
  - stall: hold all IF/ID outputs.
  - skid full: load from skid; skid cleared.
  - accepted response: load rdata/pc_F.
  - otherwise: bubble (NOP_INSTR, valid_D=0, pc_D held).
- flush beats stall when both are asserted.
- Latency: with gnt same cycle and rvalid next cycle, first valid_D is 3 cycles after reset release; sustained rate is 1 instr/cycle.
- Alignment: redirect_pc[1:0] is forced to 00; imem_addr[1:0] is always 00.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-request: state returns to IDLE; a late rvalid arriving in IDLE or REQ is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds ports perf_bubble_cnt[31:0] and perf_stall_cnt[31:0]:
  - perf_bubble_cnt increments each cycle IF/ID loads a bubble while not stalled.
  - perf_stall_cnt increments each cycle stall=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: no counters and no such ports. Core behaviour is identical in both builds.

Decomposition:
- Shared define header (defination.v) gets: NOP_INSTR encoding, RESET_PC default, the 2-bit state encodings (IDLE=00, REQ=01, WAIT=10, DROP=11).
- Sub-module fetch_skid_buf: 1-entry {instr, pc} buffer with load/drain/clear and full flag.
- PC FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, 1-cycle memory, no stall: valid_D sequence pc_D=0,4,8,12 on consecutive cycles; first valid_D=1 exactly 3 cycles after reset goes high.
- stall=1 for 2 cycles while a response for pc 0x10 arrives: instr_D holds 0x0C; after release pc_D=0x10 next cycle (from skid), then 0x14; no instruction lost or duplicated.
- flush with redirect_pc=0x80 while in WAIT, rvalid arriving 2 cycles later: that data is discarded; next valid pc_D=0x80; valid_D=0 in between.
- flush and stall together, redirect_pc=0x40: instr_D=0x00000013, valid_D=0 next cycle; next fetch address is 0x40.
- redirect_pc=0x103: imem_addr=0x100; and pc_F=0xFFFF_FFFC: next fetch addr=0x0000_0000.
- reset low for one cycle mid-WAIT with a late rvalid: all outputs return to reset values; fetch restarts at RESET_PC; the stale data never reaches instr_D.
